// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared ISA definitions for the pipelined instruction decoder.
//   Opcode field constants, destination register codes, reg_en bit indices,
//   source-select codes, NOP encodings, the decoded-control payload struct,
//   and small helper functions used by the decode logic.
package cpu_isa_pkg;

  localparam int unsigned OPC_W     = 8;
  localparam int unsigned REG_EN_W  = 9;
  localparam int unsigned SRC_SEL_W = 4;
  localparam int unsigned DST_W     = 3;

  // Opcode prefixes, matched against the top bits of the opcode byte
  localparam logic       OPC_LOAD = 1'b0;
  localparam logic [1:0] OPC_MOVE = 2'b10;
  localparam logic [2:0] OPC_ALU  = 3'b110;
  localparam logic [3:0] OPC_JMP  = 4'b1110;
  localparam logic [3:0] OPC_JNZ  = 4'b1111;

  // Destination / move-source register codes
  localparam logic [DST_W-1:0] DST_X0   = 3'd0;
  localparam logic [DST_W-1:0] DST_X1   = 3'd1;
  localparam logic [DST_W-1:0] DST_Y0   = 3'd2;
  localparam logic [DST_W-1:0] DST_Y1   = 3'd3;
  localparam logic [DST_W-1:0] DST_OREG = 3'd4;
  localparam logic [DST_W-1:0] DST_M    = 3'd5;
  localparam logic [DST_W-1:0] DST_I    = 3'd6;
  localparam logic [DST_W-1:0] DST_DM   = 3'd7;

  // Bit positions inside reg_en = {o_reg,dm,i,m,r,y1,y0,x1,x0}
  localparam int unsigned EN_X0   = 0;
  localparam int unsigned EN_X1   = 1;
  localparam int unsigned EN_Y0   = 2;
  localparam int unsigned EN_Y1   = 3;
  localparam int unsigned EN_R    = 4;
  localparam int unsigned EN_M    = 5;
  localparam int unsigned EN_I    = 6;
  localparam int unsigned EN_DM   = 7;
  localparam int unsigned EN_OREG = 8;

  localparam logic [REG_EN_W-1:0] REG_EN_ALL = '1;

  // source_sel codes above the plain register range 0..7
  localparam logic [SRC_SEL_W-1:0] SRC_IMM  = 4'd8;
  localparam logic [SRC_SEL_W-1:0] SRC_PINS = 4'd9;
  localparam logic [SRC_SEL_W-1:0] SRC_RST  = 4'd10;

  localparam logic [OPC_W-1:0] NOP_ENC0 = 8'hC8;
  localparam logic [OPC_W-1:0] NOP_ENC1 = 8'hCF;
  localparam logic [OPC_W-1:0] NOP_ENC2 = 8'hD8;
  localparam logic [OPC_W-1:0] NOP_ENC3 = 8'hDF;

  typedef struct packed {
    logic [REG_EN_W-1:0]  reg_en;
    logic [SRC_SEL_W-1:0] source_sel;
    logic                 i_sel;
    logic                 x_sel;
    logic                 y_sel;
    logic                 jmp;
    logic                 jmp_nz;
    logic                 nop;
  } dec_t;

  // Write enable for a destination code; dm writes also strobe i
  function automatic logic [REG_EN_W-1:0] dst_en(input logic [DST_W-1:0] dst);
    logic [REG_EN_W-1:0] en;
    en = '0;
    case (dst)
      DST_X0:   en[EN_X0]   = 1'b1;
      DST_X1:   en[EN_X1]   = 1'b1;
      DST_Y0:   en[EN_Y0]   = 1'b1;
      DST_Y1:   en[EN_Y1]   = 1'b1;
      DST_OREG: en[EN_OREG] = 1'b1;
      DST_M:    en[EN_M]    = 1'b1;
      DST_I:    en[EN_I]    = 1'b1;
      DST_DM: begin
        en[EN_DM] = 1'b1;
        en[EN_I]  = 1'b1;
      end
      default:  en = '0;
    endcase
    return en;
  endfunction

  function automatic logic is_nop(input logic [OPC_W-1:0] op);
    return op inside {NOP_ENC0, NOP_ENC1, NOP_ENC2, NOP_ENC3};
  endfunction

endpackage

// File: rtl/isa_decode_comb.sv
// isa_decode_comb: pure combinational opcode -> datapath control decode.
//   op_i   in  OPC_W  opcode byte of the registered instruction
//   dec_o  out dec_t  raw reg enables, source select, x/y/i selects,
//                     jump strobes and NOP flag (not qualified by handshake)
module isa_decode_comb
  import cpu_isa_pkg::*;
(
  input  logic [OPC_W-1:0] op_i,
  output dec_t             dec_o
);

  logic [DST_W-1:0] ld_dst;
  logic [DST_W-1:0] mv_dst;
  logic [DST_W-1:0] mv_src;

  assign ld_dst = op_i[6:4];
  assign mv_dst = op_i[5:3];
  assign mv_src = op_i[2:0];

  // Opcode-prefix decode; i_sel is low only when i is the destination
  always_comb begin
    dec_o       = '0;
    dec_o.i_sel = 1'b1;
    if (op_i[7] == OPC_LOAD) begin
      dec_o.reg_en     = dst_en(ld_dst);
      dec_o.source_sel = SRC_IMM;
      dec_o.i_sel      = (ld_dst != DST_I);
    end else if (op_i[7:6] == OPC_MOVE) begin
      dec_o.reg_en = dst_en(mv_dst);
      // a move out of dm (src 7) also strobes i
      if (mv_src == DST_DM) begin
        dec_o.reg_en[EN_I] = 1'b1;
      end
      // o_reg source wins over the src==dst pin-read alias
      if (mv_src == DST_OREG) begin
        dec_o.source_sel = SRC_SEL_W'(mv_src);
      end else if (mv_src == mv_dst) begin
        dec_o.source_sel = SRC_PINS;
      end else begin
        dec_o.source_sel = SRC_SEL_W'(mv_src);
      end
      dec_o.i_sel = (mv_dst != DST_I);
    end else if (op_i[7:5] == OPC_ALU) begin
      dec_o.reg_en[EN_R] = 1'b1;
      dec_o.x_sel        = op_i[4];
      dec_o.y_sel        = op_i[3];
      dec_o.source_sel   = SRC_SEL_W'(op_i[2:0]);
    end else if (op_i[7:4] == OPC_JMP) begin
      dec_o.jmp = 1'b1;
    end else if (op_i[7:4] == OPC_JNZ) begin
      dec_o.jmp_nz = 1'b1;
    end
    dec_o.nop = is_nop(op_i);
  end

endmodule

// File: rtl/instr_decoder_pipe.sv
// instr_decoder_pipe: one-stage pipelined instruction decoder.
//   Accepts instructions over instr_valid/instr_ready, holds one in a decode
//   register, and presents decoded controls to the datapath under out_ready
//   back-pressure. A taken jmp/jmp_nz squashes the next FLUSH_DEPTH accepted
//   instructions.
// Ports:
//   clk, sync_reset                 clock, synchronous active-high reset
//   instr, instr_valid, instr_ready fetch-side handshake
//   flag_nz                         ALU not-zero flag for jmp_nz
//   out_valid, out_ready            datapath-side handshake
//   ir, ir_nibble                   registered instruction and immediate field
//   reg_en, source_sel              write enables / source mux (reg_en fire-qualified)
//   i_sel, x_sel, y_sel             datapath mux selects
//   jmp, jmp_nz, nop                jump strobes (fire-qualified), NOP flag
//   instr_count, nop_count,
//   flush_count                     saturating statistics
// Build option: DECODER_STATS_EN enables the statistics counters; without it
//   the three count outputs are tied to zero.
module instr_decoder_pipe
  import cpu_isa_pkg::*;
#(
  parameter int unsigned INSTR_W     = 8,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 flag_nz,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_W-1:0]   ir,
  output logic [INSTR_W-5:0]   ir_nibble,
  output logic [REG_EN_W-1:0]  reg_en,
  output logic [SRC_SEL_W-1:0] source_sel,
  output logic                 i_sel,
  output logic                 x_sel,
  output logic                 y_sel,
  output logic                 jmp,
  output logic                 jmp_nz,
  output logic                 nop,
  output logic [CNT_W-1:0]     instr_count,
  output logic [CNT_W-1:0]     nop_count,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int unsigned LEFT_W   = 3;
  localparam logic        FLUSH_EN = (FLUSH_DEPTH != 0);
  localparam logic [0:0]  ST_RUN   = 1'b0;
  localparam logic [0:0]  ST_FLUSH = 1'b1;

  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [0:0]         state_q, state_d;
  logic [LEFT_W-1:0]  left_q, left_d;

  logic accept;
  logic fire;
  logic squash;
  logic taken;
  dec_t dec;

  assign instr_ready = ~sync_reset & (~out_valid_q | out_ready);
  assign accept      = instr_valid & instr_ready;
  assign fire        = out_valid_q & out_ready;
  assign squash      = accept & (state_q == ST_FLUSH);
  assign taken       = fire & (dec.jmp | (dec.jmp_nz & flag_nz));

  isa_decode_comb u_isa_decode_comb (
    .op_i  (ir_q[INSTR_W-1 -: OPC_W]),
    .dec_o (dec)
  );

  // Decode register: load on a non-squashed accept, empty on fire
  always_comb begin
    out_valid_d = out_valid_q;
    ir_d        = ir_q;
    if (accept && !squash) begin
      out_valid_d = 1'b1;
      ir_d        = instr;
    end else if (fire) begin
      out_valid_d = 1'b0;
    end
  end

  // Branch-shadow squash FSM; a fresh taken jump restarts the count
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    if (taken && FLUSH_EN) begin
      state_d = ST_FLUSH;
      left_d  = LEFT_W'(FLUSH_DEPTH);
    end else if ((state_q == ST_FLUSH) && accept) begin
      if (left_q == LEFT_W'(1)) begin
        state_d = ST_RUN;
        left_d  = '0;
      end else begin
        left_d  = left_q - LEFT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      out_valid_q <= 1'b0;
      ir_q        <= '0;
      state_q     <= ST_RUN;
      left_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ir_q        <= ir_d;
      state_q     <= state_d;
      left_q      <= left_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ir        = ir_q;
  assign ir_nibble = ir_q[INSTR_W-5:0];

  // Datapath controls; reset forces the clear-all pattern
  always_comb begin
    reg_en     = fire ? dec.reg_en : '0;
    source_sel = dec.source_sel;
    i_sel      = dec.i_sel;
    x_sel      = dec.x_sel;
    y_sel      = dec.y_sel;
    jmp        = fire & dec.jmp;
    jmp_nz     = fire & dec.jmp_nz;
    nop        = dec.nop;
    if (sync_reset) begin
      reg_en     = REG_EN_ALL;
      source_sel = SRC_RST;
      i_sel      = 1'b0;
      x_sel      = 1'b0;
      y_sel      = 1'b0;
      jmp        = 1'b0;
      jmp_nz     = 1'b0;
      nop        = 1'b0;
    end
  end

`ifdef DECODER_STATS_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] nop_cnt_q, nop_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    nop_cnt_d   = nop_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fire && (instr_cnt_q != '1)) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
    if (fire && dec.nop && (nop_cnt_q != '1)) begin
      nop_cnt_d = nop_cnt_q + CNT_W'(1);
    end
    if (squash && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      instr_cnt_q <= '0;
      nop_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      nop_cnt_q   <= nop_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign instr_count = instr_cnt_q;
  assign nop_count   = nop_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign instr_count = '0;
  assign nop_count   = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Self-checking bench for instr_decoder_pipe: table of decode vectors plus
// hand-written handshake/flush/reset sequences, checked through a scoreboard.
module tb_instr_decoder_pipe;

  localparam int unsigned INSTR_W     = 8;
  localparam int unsigned FLUSH_DEPTH = 1;
  localparam int unsigned CNT_W       = 16;

  logic               clk = 1'b0;
  logic               sync_reset;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               flag_nz;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-5:0] ir_nibble;
  logic [8:0]         reg_en;
  logic [3:0]         source_sel;
  logic               i_sel, x_sel, y_sel, jmp, jmp_nz, nop;
  logic [CNT_W-1:0]   instr_count, nop_count, flush_count;

  instr_decoder_pipe #(
    .INSTR_W(INSTR_W), .FLUSH_DEPTH(FLUSH_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .sync_reset(sync_reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flag_nz(flag_nz), .out_valid(out_valid),
    .out_ready(out_ready), .ir(ir), .ir_nibble(ir_nibble), .reg_en(reg_en),
    .source_sel(source_sel), .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel),
    .jmp(jmp), .jmp_nz(jmp_nz), .nop(nop), .instr_count(instr_count),
    .nop_count(nop_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic [8:0] reg_en;
    logic [3:0] sel;
    logic       i_sel, x_sel, y_sel, jmp, jmp_nz, nop;
  } vec_t;

  vec_t tbl[15];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic exp_valid = 1'b0;
  int   flush_left = 0;
  int   exp_ic = 0, exp_nc = 0, exp_fc = 0;

  function automatic vec_t mk(input logic [7:0] i, input logic [8:0] e, input logic [3:0] s,
                              input logic is, input logic xs, input logic ys,
                              input logic j, input logic jn, input logic n);
    vec_t v;
    v.instr = i; v.reg_en = e; v.sel = s;
    v.i_sel = is; v.x_sel = xs; v.y_sel = ys; v.jmp = j; v.jmp_nz = jn; v.nop = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_counts();
`ifdef DECODER_STATS_EN
    chk("instr_count", instr_count, exp_ic);
    chk("nop_count", nop_count, exp_nc);
    chk("flush_count", flush_count, exp_fc);
`else
    chk("instr_count", instr_count, 0);
    chk("nop_count", nop_count, 0);
    chk("flush_count", flush_count, 0);
`endif
  endtask

  // One clock: drive at negedge, check settled outputs, then advance the model
  task automatic step(input logic v, input vec_t vv, input logic rdy, input logic fnz,
                      output logic acc_o);
    logic exp_rdy, acc, sq, fire_e, taken;
    vec_t hd;
    @(negedge clk);
    sync_reset = 1'b0; instr_valid = v; instr = vv.instr; out_ready = rdy; flag_nz = fnz;
    #1;
    exp_rdy = !exp_valid || rdy;
    chk("instr_ready", instr_ready, exp_rdy);
    chk("out_valid", out_valid, exp_valid);
    chk_counts();
    fire_e = exp_valid && rdy;
    taken  = 1'b0;
    if (exp_valid && sb.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard at %0t: got empty queue expected an entry", $time);
    end else if (exp_valid) begin
      hd = sb[0];
      chk("ir", ir, hd.instr);
      chk("ir_nibble", ir_nibble, hd.instr[3:0]);
      chk("i_sel", i_sel, hd.i_sel);
      chk("x_sel", x_sel, hd.x_sel);
      chk("y_sel", y_sel, hd.y_sel);
      chk("nop", nop, hd.nop);
      if (!(hd.jmp || hd.jmp_nz)) chk("source_sel", source_sel, hd.sel);
      chk("reg_en", reg_en, fire_e ? hd.reg_en : 9'h000);
      chk("jmp", jmp, fire_e && hd.jmp);
      chk("jmp_nz", jmp_nz, fire_e && hd.jmp_nz);
      if (fire_e) begin
        taken = hd.jmp || (hd.jmp_nz && fnz);
        exp_ic++;
        if (hd.nop) exp_nc++;
        void'(sb.pop_front());
      end
    end else begin
      chk("reg_en_idle", reg_en, 9'h000);
      chk("jmp_idle", jmp, 1'b0);
      chk("jmp_nz_idle", jmp_nz, 1'b0);
    end
    acc = v && exp_rdy;
    sq  = acc && (flush_left > 0);
    if (sq) exp_fc++;
    if (taken) flush_left = FLUSH_DEPTH;
    else if (sq) flush_left--;
    if (acc && !sq) begin
      sb.push_back(vv);
      exp_valid = 1'b1;
    end else if (fire_e) begin
      exp_valid = 1'b0;
    end
    acc_o = acc;
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sync_reset = 1'b1; instr_valid = 1'b1; instr = 8'hE3; out_ready = 1'b1; flag_nz = 1'b1;
      #1;
      chk("rst_reg_en", reg_en, 9'h1FF);
      chk("rst_source_sel", source_sel, 4'd10);
      chk("rst_instr_ready", instr_ready, 1'b0);
      chk("rst_sel_xyi", {i_sel, x_sel, y_sel}, 3'b000);
      chk("rst_jmp", {jmp, jmp_nz, nop}, 3'b000);
      if (k > 0) begin
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_flush_count", flush_count, 0);
      end
    end
    sb.delete();
    exp_valid = 1'b0; flush_left = 0;
    exp_ic = 0; exp_nc = 0; exp_fc = 0;
  endtask

  initial begin
    logic acc;
    vec_t idle, vE3, vF3, v21, v22, v23, v24;
    int   idx;

    sync_reset = 1'b1; instr_valid = 1'b0; instr = 8'h00; out_ready = 1'b0; flag_nz = 1'b0;

    //         instr   reg_en  sel  i  x  y  j jn nop
    tbl[0]  = mk(8'h35, 9'h008, 8, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(8'hBA, 9'h0C0, 2, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(8'h92, 9'h004, 9, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(8'h8C, 9'h002, 4, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(8'h60, 9'h040, 8, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(8'h4F, 9'h100, 8, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(8'hB7, 9'h040, 7, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(8'h87, 9'h041, 7, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(8'hA4, 9'h100, 4, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(8'hAD, 9'h020, 9, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(8'hC8, 9'h010, 0, 1, 0, 1, 0, 0, 1);
    tbl[11] = mk(8'hDF, 9'h010, 7, 1, 1, 1, 0, 0, 1);
    tbl[12] = mk(8'hD5, 9'h010, 5, 1, 1, 0, 0, 0, 0);
    tbl[13] = mk(8'hCF, 9'h010, 7, 1, 0, 1, 0, 0, 1);
    tbl[14] = mk(8'h7A, 9'h0C0, 8, 1, 0, 0, 0, 0, 0);
    idle = mk(8'h00, 9'h001, 8, 1, 0, 0, 0, 0, 0);
    vE3  = mk(8'hE3, 9'h000, 0, 1, 0, 0, 1, 0, 0);
    vF3  = mk(8'hF3, 9'h000, 0, 1, 0, 0, 0, 1, 0);
    v21  = mk(8'h21, 9'h004, 8, 1, 0, 0, 0, 0, 0);
    v22  = mk(8'h22, 9'h004, 8, 1, 0, 0, 0, 0, 0);
    v23  = mk(8'h23, 9'h004, 8, 1, 0, 0, 0, 0, 0);
    v24  = mk(8'h24, 9'h004, 8, 1, 0, 0, 0, 0, 0);

    // Reset, then release with an empty pipe
    do_reset(2);
    step(1'b0, idle, 1'b1, 1'b0, acc);

    // Back-to-back table stream with the datapath always ready
    for (int i = 0; i < 15; i++) step(1'b1, tbl[i], 1'b1, 1'b0, acc);
    for (int i = 0; i < 2; i++) step(1'b0, idle, 1'b1, 1'b0, acc);

    // Random valid/ready throttling over the table
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      step(1'($urandom_range(0, 1)), tbl[idx], 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) idx = (idx + 1) % 15;
    end
    for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, 1'b0, acc);

    // Stall: NOP held three cycles, a pending instr must not be taken
    step(1'b1, tbl[10], 1'b1, 1'b0, acc);
    step(1'b1, tbl[0], 1'b0, 1'b0, acc);
    step(1'b1, tbl[0], 1'b0, 1'b0, acc);
    step(1'b1, tbl[0], 1'b0, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);

    // Taken jmp squashes the next accepted instruction
    step(1'b1, vE3, 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);
    step(1'b1, v21, 1'b1, 1'b0, acc);
    step(1'b1, v22, 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);

    // jmp_nz not taken, then taken
    step(1'b1, vF3, 1'b1, 1'b0, acc);
    step(1'b1, v21, 1'b1, 1'b0, acc);
    step(1'b1, vF3, 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b1, acc);
    step(1'b1, v23, 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);

    // Reset while flushing returns to RUN: next instr is decoded
    step(1'b1, vF3, 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b1, acc);
    do_reset(1);
    step(1'b1, v24, 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);
    step(1'b0, idle, 1'b1, 1'b0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
